moving_blob_anim: RTL and testbench
===================================

Name: moving_blob_anim

Overview:
- Sequential successor to the static blob renderer.
- Draws a WIDTH x HEIGHT solid blob and animates a "caterpillar" move from a start x to a target x, either left or right. The move runs in three phases: stretch toward the target, slide, then shrink back.
- Geometry updates only on the per-frame strobe, so every frame is drawn coherently.
- Sits in the sprite layer. It is fed by the VGA timing hcount/vcount and by game logic that issues move commands.

Parameters:
- WIDTH, 64, blob width in pixels.
- HEIGHT, 64, blob height in pixels.
- COLOR, 12'hFFF, 12-bit RGB colour of the blob.
- MAX_STRETCH, 32, maximum extra length in pixels added during the stretch phase.
- STEP, 4, pixels moved or stretched per frame; must be ≥1 and ≤ MAX_STRETCH.

Ports:
- clk_in  input  1  pixel clock.
- rst_n_in  input  1  asynchronous, active-low reset.
- start_in  input  1  one-cycle move request; sampled only in IDLE.
- x_start_in  input  11  blob left edge at the start of the move.
- x_target_in  input  11  blob left edge at the end of the move.
- y_in  input  10  blob top edge; used live, not latched.
- frame_in  input  1  one-cycle strobe once per frame, issued during vblank.
- hcount_in  input  11  current pixel x.
- vcount_in  input  10  current pixel y.
- pixel_out  output  12  COLOR inside the blob, 0 elsewhere; registered.
- busy_out  output  1  high whenever state ≠ IDLE.
- done_out  output  1  one-cycle pulse on move completion.

Behaviour:
- Reset (async, rst_n_in=0):
  - state=IDLE, x_pos=0, stretch=0, dir=0.
  - pixel_out=0, busy_out=0, done_out=0.
  - Asserting reset mid-move aborts the move immediately; no done pulse.
- Registers:
  - x_pos, 11 bits.
  - stretch, $clog2(MAX_STRETCH+1) bits.
  - dir: 0 = right, 1 = left.
- Horizontal span (12-bit arithmetic, no wrap):
  - dir=0: [x_pos, x_pos+WIDTH+stretch).
  - dir=1: [x_pos-stretch, x_pos+WIDTH). A negative left bound clips to 0.
- Vertical span: [y_in, y_in+HEIGHT).
- pixel_out: registered, 1-cycle latency. It reflects the hcount_in/vcount_in values of the previous clock.
- State machine (states IDLE, STRETCH, SLIDE, SHRINK, DONE):
  - IDLE, start_in=1:
    - x_pos<=x_start_in, stretch<=0, dir<=(x_target_in<x_start_in).
    - If x_target_in==x_start_in, go to DONE; otherwise go to STRETCH.
    - Target is latched internally at start; later changes to x_target_in are ignored.
  - STRETCH, on frame_in:
    - stretch <= min(stretch+STEP, MAX_STRETCH).
    - Go to SLIDE on the frame where the new value equals MAX_STRETCH.
  - SLIDE, on frame_in:
    - If |target−x_pos| ≤ STEP: x_pos<=target and go to SHRINK.
    - Otherwise x_pos moves STEP toward target.
    - stretch holds.
  - SHRINK, on frame_in:
    - stretch <= max(stretch−STEP, 0).
    - Go to DONE on the frame where the new value is 0.
  - DONE: done_out=1 for exactly one cycle, then IDLE unconditionally.
- Output decode: busy_out and done_out decode directly from the state register.
- Outside of frame_in: STRETCH/SLIDE/SHRINK hold all geometry when frame_in=0.
- Ignored requests: start_in outside IDLE is ignored and is not queued.
- start_in and frame_in in the same IDLE cycle: start wins. The first motion step happens on the next frame_in.
- IDLE geometry: x_pos holds its last value and stretch=0, so the blob keeps being drawn at rest.

Test Plan:
- Reset: hold rst_n_in low, then release.
  - Expect pixel_out=0, busy_out=0, done_out=0.
  - With x_pos=0, scanning hcount=10/vcount=y_in+5 gives pixel_out=12'hFFF one cycle later.
- Right move, start 100 → target 200, defaults.
  - Expect 8 frames of STRETCH, reaching span [100,196); at hcount=195 pixel_out=FFF, at 196 pixel_out=0.
  - Then 25 SLIDE frames ending at x_pos=200, then 8 SHRINK frames.
  - done_out pulses once; busy_out is high throughout.
- Left move with clamp, start 300 → target 298.
  - dir=1; after STRETCH the span is [268,364).
  - One SLIDE frame clamps x_pos=298, then 8 SHRINK frames, final span [298,362), then the done pulse.
- Zero move, start 50 → target 50.
  - busy_out high and done_out high in the cycle after start_in, both low the cycle after that.
  - No frame_in is needed.
- Command filtering:
  - start_in during SLIDE with different inputs is ignored; the trajectory is unchanged.
  - Simultaneous start_in and frame_in in IDLE: stretch is still 0 after that cycle.
- Mid-move reset: assert rst_n_in during SLIDE, with no clock edge.
  - Outputs clear immediately and state=IDLE.
  - After release, a new start 0 → 8 completes normally.

Source files
------------

// File: rtl/moving_blob_anim.sv
// Sprite-layer blob that animates a caterpillar move (stretch, slide, shrink)
// between two x positions, stepping geometry once per frame strobe.
module moving_blob_anim #(
  parameter int          WIDTH       = 64,
  parameter int          HEIGHT      = 64,
  parameter logic [11:0] COLOR       = 12'hFFF,
  parameter int          MAX_STRETCH = 32,
  parameter int          STEP        = 4
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        start_in,
  input  logic [10:0] x_start_in,
  input  logic [10:0] x_target_in,
  input  logic [9:0]  y_in,
  input  logic        frame_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  output logic [11:0] pixel_out,
  output logic        busy_out,
  output logic        done_out
);
  localparam int SW = $clog2(MAX_STRETCH + 1);
  localparam logic [11:0]   C_STEP  = 12'(STEP);
  localparam logic [11:0]   C_MAX   = 12'(MAX_STRETCH);
  localparam logic [11:0]   C_W     = 12'(WIDTH);
  localparam logic [10:0]   C_H     = 11'(HEIGHT);
  localparam logic [10:0]   C_STEP11 = 11'(STEP);
  localparam logic [SW-1:0] C_MAX_S = SW'(MAX_STRETCH);

  typedef enum logic [2:0] {S_IDLE, S_STRETCH, S_SLIDE, S_SHRINK, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [10:0]   r_x_pos, w_x_nxt;
  logic [10:0]   r_target, w_target_nxt;
  logic [SW-1:0] r_stretch, w_stretch_nxt;
  logic          r_dir, w_dir_nxt;
  logic [11:0]   r_pixel;

  logic [11:0] w_x12, w_s12, w_tgt12, w_sum, w_diff, w_dist;
  logic [11:0] w_left, w_right, w_h12;
  logic [10:0] w_v11, w_y11, w_ybot;
  logic        w_in;

  assign w_x12   = {1'b0, r_x_pos};
  assign w_s12   = {{(12-SW){1'b0}}, r_stretch};
  assign w_tgt12 = {1'b0, r_target};
  assign w_sum   = w_s12 + C_STEP;
  assign w_diff  = (w_s12 > C_STEP) ? (w_s12 - C_STEP) : 12'd0;
  // Direction is fixed for the whole move, so distance never goes negative.
  assign w_dist  = r_dir ? (w_x12 - w_tgt12) : (w_tgt12 - w_x12);

  always_comb begin
    w_state_nxt   = r_state;
    w_x_nxt       = r_x_pos;
    w_target_nxt  = r_target;
    w_stretch_nxt = r_stretch;
    w_dir_nxt     = r_dir;
    case (r_state)
      S_IDLE: if (start_in) begin
        w_x_nxt       = x_start_in;
        w_target_nxt  = x_target_in;
        w_stretch_nxt = '0;
        w_dir_nxt     = (x_target_in < x_start_in);
        w_state_nxt   = (x_target_in == x_start_in) ? S_DONE : S_STRETCH;
      end
      S_STRETCH: if (frame_in) begin
        if (w_sum >= C_MAX) begin
          w_stretch_nxt = C_MAX_S;
          w_state_nxt   = S_SLIDE;
        end else begin
          w_stretch_nxt = w_sum[SW-1:0];
        end
      end
      S_SLIDE: if (frame_in) begin
        if (w_dist <= C_STEP) begin
          w_x_nxt     = r_target;
          w_state_nxt = S_SHRINK;
        end else begin
          w_x_nxt = r_dir ? (r_x_pos - C_STEP11) : (r_x_pos + C_STEP11);
        end
      end
      S_SHRINK: if (frame_in) begin
        w_stretch_nxt = w_diff[SW-1:0];
        if (w_diff == 12'd0) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state   <= S_IDLE;
      r_x_pos   <= '0;
      r_target  <= '0;
      r_stretch <= '0;
      r_dir     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_x_pos   <= w_x_nxt;
      r_target  <= w_target_nxt;
      r_stretch <= w_stretch_nxt;
      r_dir     <= w_dir_nxt;
    end
  end

  // Left-moving blob grows backwards from x_pos; clip at the screen edge.
  assign w_left  = r_dir ? ((w_x12 < w_s12) ? 12'd0 : (w_x12 - w_s12)) : w_x12;
  assign w_right = r_dir ? (w_x12 + C_W) : (w_x12 + C_W + w_s12);
  assign w_h12   = {1'b0, hcount_in};
  assign w_v11   = {1'b0, vcount_in};
  assign w_y11   = {1'b0, y_in};
  assign w_ybot  = w_y11 + C_H;
  assign w_in    = (w_h12 >= w_left) && (w_h12 < w_right) &&
                   (w_v11 >= w_y11) && (w_v11 < w_ybot);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_pixel <= '0;
    else           r_pixel <= w_in ? COLOR : 12'h000;
  end

  assign pixel_out = r_pixel;
  assign busy_out  = (r_state != S_IDLE);
  assign done_out  = (r_state == S_DONE);
endmodule

// File: tb/tb_moving_blob_anim.sv
// Directed plus randomized bench for moving_blob_anim against a frame-level model.
module tb_moving_blob_anim;
  logic        clk_in = 1'b0;
  logic        rst_n_in, start_in, frame_in;
  logic [10:0] x_start_in, x_target_in, hcount_in;
  logic [9:0]  y_in, vcount_in;
  logic [11:0] pixel_out;
  logic        busy_out, done_out;

  moving_blob_anim dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in),
    .x_start_in(x_start_in), .x_target_in(x_target_in), .y_in(y_in),
    .frame_in(frame_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .pixel_out(pixel_out), .busy_out(busy_out), .done_out(done_out)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0, failures = 0;

  // Model: phase 0 idle, 1 stretch, 2 slide, 3 shrink, 4 done.
  int m_x, m_s, m_dir, m_tgt, m_ph;

  function automatic int m_left();
    int l;
    if (m_dir != 0) begin l = m_x - m_s; if (l < 0) l = 0; end
    else l = m_x;
    return l;
  endfunction

  function automatic int m_right();
    return (m_dir != 0) ? m_x + 64 : m_x + 64 + m_s;
  endfunction

  function automatic logic [11:0] m_pix(int h, int v);
    int y;
    y = int'(y_in);
    return (h >= m_left() && h < m_right() && v >= y && v < y + 64) ? 12'hFFF : 12'h000;
  endfunction

  task automatic m_reset();
    m_x = 0; m_s = 0; m_dir = 0; m_tgt = 0; m_ph = 0;
  endtask

  task automatic m_update(logic f, logic s);
    int d;
    case (m_ph)
      0: if (s) begin
        m_x = int'(x_start_in); m_tgt = int'(x_target_in); m_s = 0;
        m_dir = (m_tgt < m_x) ? 1 : 0;
        m_ph = (m_tgt == m_x) ? 4 : 1;
      end
      1: if (f) begin
        m_s = (m_s + 4 > 32) ? 32 : m_s + 4;
        if (m_s == 32) m_ph = 2;
      end
      2: if (f) begin
        d = m_tgt - m_x;
        if (d <= 4 && d >= -4) begin m_x = m_tgt; m_ph = 3; end
        else m_x = m_x + ((d > 0) ? 4 : -4);
      end
      3: if (f) begin
        m_s = (m_s - 4 < 0) ? 0 : m_s - 4;
        if (m_s == 0) m_ph = 4;
      end
      default: m_ph = 0;
    endcase
  endtask

  task automatic chk(string tag, logic [11:0] obs, logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(logic f, logic s, int h, int v);
    logic [11:0] ep;
    frame_in = f; start_in = s;
    hcount_in = h[10:0]; vcount_in = v[9:0];
    ep = m_pix(h, v);
    m_update(f, s);
    @(posedge clk_in); #1;
    chk("pixel", pixel_out, ep);
    chk("busy", {11'b0, busy_out}, {11'b0, m_ph != 0});
    chk("done", {11'b0, done_out}, {11'b0, m_ph == 4});
    frame_in = 1'b0; start_in = 1'b0;
  endtask

  function automatic int clampi(int a, int lo, int hi);
    return (a < lo) ? lo : (a > hi) ? hi : a;
  endfunction

  task automatic rcyc(logic f, logic s);
    int h, v, y;
    y = int'(y_in);
    case ($urandom_range(0, 4))
      0: h = m_left() - 1;
      1: h = m_left();
      2: h = m_right() - 1;
      3: h = m_right();
      default: h = int'($urandom_range(0, 2047));
    endcase
    case ($urandom_range(0, 4))
      0: v = y - 1;
      1: v = y + 63;
      2: v = y + 64;
      default: v = y + int'($urandom_range(0, 63));
    endcase
    cyc(f, s, clampi(h, 0, 2047), clampi(v, 0, 1023));
  endtask

  task automatic frames(int n);
    for (int i = 0; i < n; i++) begin rcyc(1'b1, 1'b0); rcyc(1'b0, 1'b0); end
  endtask

  task automatic run_move(int xs, int xt);
    int n;
    x_start_in = xs[10:0]; x_target_in = xt[10:0];
    rcyc(1'b0, 1'b1);
    n = 0;
    while ((m_ph != 0 || busy_out) && n < 4000) begin
      rcyc($urandom_range(0, 2) == 0, 1'b0);
      n++;
    end
    if (n >= 4000) begin
      checks++; failures++;
      $error("FAIL move_timeout observed=busy expected=idle");
    end
  endtask

  initial begin
    int xs, xt;
    rst_n_in = 1'b0; start_in = 1'b0; frame_in = 1'b0;
    x_start_in = '0; x_target_in = '0; y_in = 10'd100;
    hcount_in = '0; vcount_in = '0;
    m_reset();
    #22;
    chk("rst_pixel", pixel_out, 12'h000);
    chk("rst_busy", {11'b0, busy_out}, 12'h000);
    chk("rst_done", {11'b0, done_out}, 12'h000);
    @(negedge clk_in); rst_n_in = 1'b1;
    cyc(1'b0, 1'b0, 10, 105);
    chk("rst_scan", pixel_out, 12'hFFF);

    // Right move 100 -> 200
    x_start_in = 11'd100; x_target_in = 11'd200;
    rcyc(1'b0, 1'b1);
    frames(8);
    cyc(1'b0, 1'b0, 195, 105); chk("r_span_in", pixel_out, 12'hFFF);
    cyc(1'b0, 1'b0, 196, 105); chk("r_span_out", pixel_out, 12'h000);
    frames(3);
    x_start_in = 11'd7; x_target_in = 11'd900;
    rcyc(1'b0, 1'b1);
    chk("r_ignored_start", {11'b0, busy_out}, 12'h001);
    frames(22);
    cyc(1'b0, 1'b0, 199, 105); chk("r_slide_l", pixel_out, 12'h000);
    cyc(1'b0, 1'b0, 200, 105); chk("r_slide_in", pixel_out, 12'hFFF);
    frames(7);
    chk("r_busy_shrink", {11'b0, busy_out}, 12'h001);
    rcyc(1'b1, 1'b0);
    chk("r_done_pulse", {11'b0, done_out}, 12'h001);
    rcyc(1'b0, 1'b0);
    chk("r_done_clear", {11'b0, done_out}, 12'h000);

    // Left move with clamp 300 -> 298
    x_start_in = 11'd300; x_target_in = 11'd298;
    rcyc(1'b0, 1'b1);
    frames(8);
    cyc(1'b0, 1'b0, 267, 130); chk("l_span_lo_out", pixel_out, 12'h000);
    cyc(1'b0, 1'b0, 268, 130); chk("l_span_lo_in", pixel_out, 12'hFFF);
    cyc(1'b0, 1'b0, 363, 130); chk("l_span_hi_in", pixel_out, 12'hFFF);
    cyc(1'b0, 1'b0, 364, 130); chk("l_span_hi_out", pixel_out, 12'h000);
    frames(1);
    rcyc(1'b0, 1'b0);
    frames(7);
    rcyc(1'b1, 1'b0);
    chk("l_done_pulse", {11'b0, done_out}, 12'h001);
    cyc(1'b0, 1'b0, 297, 130); chk("l_final_lo", pixel_out, 12'h000);
    cyc(1'b0, 1'b0, 298, 130); chk("l_final_in", pixel_out, 12'hFFF);
    cyc(1'b0, 1'b0, 362, 130); chk("l_final_hi", pixel_out, 12'h000);

    // Zero move
    x_start_in = 11'd50; x_target_in = 11'd50;
    rcyc(1'b0, 1'b1);
    chk("z_busy", {11'b0, busy_out}, 12'h001);
    chk("z_done", {11'b0, done_out}, 12'h001);
    rcyc(1'b0, 1'b0);
    chk("z_busy_clr", {11'b0, busy_out}, 12'h000);
    chk("z_done_clr", {11'b0, done_out}, 12'h000);

    // Start and frame together in IDLE: start wins, no stretch yet
    x_start_in = 11'd400; x_target_in = 11'd500;
    rcyc(1'b1, 1'b1);
    cyc(1'b0, 1'b0, 463, 110); chk("sf_in", pixel_out, 12'hFFF);
    cyc(1'b0, 1'b0, 464, 110); chk("sf_nostretch", pixel_out, 12'h000);
    while (m_ph != 0) rcyc($urandom_range(0, 1) == 0, 1'b0);

    // Mid-move reset during SLIDE, checked before any clock edge
    x_start_in = 11'd0; x_target_in = 11'd400;
    rcyc(1'b0, 1'b1);
    frames(12);
    chk("mr_in_slide", {11'b0, busy_out}, 12'h001);
    #2 rst_n_in = 1'b0;
    #1;
    chk("mr_pixel", pixel_out, 12'h000);
    chk("mr_busy", {11'b0, busy_out}, 12'h000);
    chk("mr_done", {11'b0, done_out}, 12'h000);
    m_reset();
    @(negedge clk_in); rst_n_in = 1'b1;
    run_move(0, 8);

    // Randomized moves with random vertical placement
    for (int k = 0; k < 15; k++) begin
      y_in = 10'($urandom_range(0, 900));
      xs = int'($urandom_range(0, 1500));
      xt = clampi(xs + int'($urandom_range(0, 600)) - 300, 0, 2000);
      run_move(xs, xt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
